if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the 5-stage MIPS pipeline, sitting directly upstream of the IF/ID pipeline register. It owns the fetch PC (`PCF`), issues word fetches to instruction memory over a req/ack handshake, and honours the hazard unit's stall and the decode stage's branch/jump redirect. It presents one instruction per cycle, or a NOP bubble, on `Ins`/`PCPlus4F` for the IF/ID register to capture.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset.
- `clk`  in  1  pipeline clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `StallF`  in  1  hazard-unit stall, high = hold; `PCF` and the buffered instruction are frozen.
- `PCSrcD`  in  1  redirect request from decode, high = load `PCBranchD`.
- `PCBranchD`  in  32  redirect target.
- `imem_req`  out  1  fetch request, held until `imem_ack`.
- `imem_addr`  out  32  fetch address, equal to `PCF`, stable while `imem_req` is high.
- `imem_ack`  in  1  read data valid; may be asserted in the same cycle as `imem_req` (zero-wait).
- `imem_rdata`  in  32  instruction word, valid when `imem_ack` is high.
- `Ins`  out  32  instruction to IF/ID; 32'h0 (NOP) when `InsValidF` is low.
- `InsValidF`  out  1  high when `Ins` holds a real fetched instruction.
- `PCF`  out  32  current fetch PC.
- `PCPlus4F`  out  32  `PCF + 4`, modulo 2^32.
- `FetchErrF`  out  1  misaligned-redirect flag (see Configuration).

## Operation
- Reset (`rst` = 0 at an edge): `PCF` = `RESET_PC`, state = S_REQ, buffer = 0, kill = 0, `FetchErrF` = 0. While `rst` = 0: `imem_req` = 0, `Ins` = 0, `InsValidF` = 0.
- **S_REQ**: `imem_req` = 1, `imem_addr` = `PCF`.
  - `imem_ack` with no kill: `Ins` = `imem_rdata` and `InsValidF` = 1 in that cycle (combinational bypass).
    - If `StallF` = 0: `PCF` is loaded with the next PC and the state stays S_REQ.
    - If `StallF` = 1: the word is captured into the buffer and the state moves to S_HAVE.
  - No ack and `PCSrcD` = 1: `PCF` = `PCBranchD`, the kill flag is set, and the state moves to S_KILL.
  - No ack and no redirect: hold all state, whatever `StallF` is.
- **S_KILL**: `imem_req` = 1 with `imem_addr` equal to the old address, so the outstanding beat completes. `InsValidF` = 0.
  - On `imem_ack`: the data is discarded, kill is cleared, and the state moves to S_REQ (fetching the new `PCF`).
  - A further `PCSrcD` in S_KILL updates `PCF` again; the old address is held in a separate `kill_addr` register.
- **S_HAVE**: `imem_req` = 0, `Ins` = buffer, `InsValidF` = 1.
  - `StallF` = 0: load `PCF` with the next PC and move to S_REQ.
  - `StallF` = 1: hold; `PCSrcD` is ignored, because the hazard unit keeps it asserted until the stall releases.
- Next PC = `PCBranchD` if `PCSrcD` = 1, else `PCF + 4`. A redirect while the IF/ID register is advancing relies on the decode-side clear to squash the wrong-path instruction; this block does not suppress it.
- Arithmetic: all PC math is 32-bit unsigned. 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Zero-wait memory (ack in the same cycle as req): one instruction per cycle, latency 0 from address to `Ins`.
- N-cycle memory: `InsValidF` = 0 for N cycles, then 1 for one cycle (if not stalled).
- Redirect penalty with an outstanding miss: the remaining cycles of the old beat, plus the new fetch latency.
- `PCPlus4F` is combinational from `PCF` and valid every cycle, including reset.
- Simultaneous `imem_ack` and `PCSrcD` in S_REQ:
  - `StallF` = 0: the data is delivered and `PCF` = `PCBranchD`.
  - `StallF` = 1: the data is buffered and the redirect is ignored.
- Reset mid-fetch: the outstanding ack is ignored because `imem_req` drops. The memory side must abandon the beat on `imem_req` = 0.

## Configuration
- `IF_MISALIGN_CHK_EN` defined:
  - A redirect with `PCBranchD[1:0]` ≠ 0 loads `{PCBranchD[31:2], 2'b00}` and sets `FetchErrF`.
  - `FetchErrF` is sticky until reset.
- `IF_MISALIGN_CHK_EN` undefined:
  - `PCBranchD` is loaded unchanged.
  - `FetchErrF` is tied to 0 and the check logic is not synthesised.

## Structure
- Shared pipeline package holds:
  - the fetch state encoding (S_REQ, S_HAVE, S_KILL);
  - `NOP_INSTR` = 32'h0;
  - `PC_STEP` = 4;
  - the default `RESET_PC`.
- One sub-module, `if_pc_reg`:
  - the PC register with reset/load/hold, next-PC mux and +4 adder;
  - it owns the misaligned check when enabled.
- The handshake state machine and instruction buffer live in `if_stage`.

## Test plan
- **Reset, zero-wait memory.** Setup: `RESET_PC` = 32'h0040_0000, ack tied to req, rdata = address. Drive `rst` low then high. Expect:
  - `imem_addr` = 0x400000, 0x400004, 0x400008 on consecutive cycles;
  - `Ins` equal to those values;
  - `InsValidF` = 1 every cycle.
- **3-wait memory.** Expect:
  - `InsValidF` pattern 0,0,0,1 per fetch;
  - `PCF` advances by 4 only on ack cycles.
- **Stall in S_HAVE.** Ack 0x8C010004 with `StallF` = 1 for 3 cycles. Expect:
  - `Ins` = 0x8C010004 held;
  - `imem_req` = 0;
  - `PCF` unchanged;
  - release gives `PCF` + 4 and `imem_req` = 1.
- **Redirect during an outstanding miss.** Miss at 0x100; `PCSrcD` = 1, `PCBranchD` = 0x200 before ack. Expect:
  - the 0x100 data is discarded;
  - the next request has `imem_addr` = 0x200;
  - no `InsValidF` pulse for 0x100.
- **PC wrap.** `PCF` = 0xFFFF_FFFC. Expect:
  - `PCPlus4F` = 0;
  - next fetch address = 0.
- **Misaligned redirect, with `IF_MISALIGN_CHK_EN`.** `PCBranchD` = 0x203. Expect:
  - `PCF` = 0x200;
  - `FetchErrF` = 1 and stays 1 until `rst` = 0.
- **Same stimulus, without `IF_MISALIGN_CHK_EN`.** Expect:
  - `PCF` = 0x203;
  - `FetchErrF` = 0.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared fetch-stage definitions: state encoding and PC constants.
// Imported by if_pc_reg and if_stage.
package if_stage_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HAVE = 2'd1,
        S_KILL = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
    localparam logic [31:0] PC_STEP      = 32'd4;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/if_pc_reg.sv
// Fetch PC register: reset/load/hold, next-PC mux and +4 adder.
// Optional misaligned-redirect check under IF_MISALIGN_CHK_EN.
module if_pc_reg
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld,
    input  logic        redir,
    input  logic [31:0] target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        err
);

    logic [31:0] pc_q;
    logic [31:0] tgt;
    logic [31:0] nxt;

    assign pc_plus4 = pc_q + PC_STEP;
    assign pc       = pc_q;

`ifdef IF_MISALIGN_CHK_EN
    logic mis;
    logic err_q;

    assign mis = redir && (target[1:0] != 2'b00);
    assign tgt = {target[31:2], 2'b00};
    assign err = err_q;

    // Sticky error on any taken misaligned redirect
    always_ff @(posedge clk) begin
        if (!rst)
            err_q <= 1'b0;
        else if (ld && mis)
            err_q <= 1'b1;
    end
`else
    assign tgt = target;
    assign err = 1'b0;
`endif

    assign nxt = redir ? tgt : pc_plus4;

    // PC register with synchronous reset and load enable
    always_ff @(posedge clk) begin
        if (!rst)
            pc_q <= RESET_PC;
        else if (ld)
            pc_q <= nxt;
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: imem req/ack handshake, stall buffer, redirect kill.
// Build option: IF_MISALIGN_CHK_EN enables the misaligned-redirect flag.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        PCSrcD,
    input  logic [31:0] PCBranchD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Ins,
    output logic        InsValidF,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        FetchErrF
);

    fetch_state_t state;
    fetch_state_t nstate;

    logic [31:0] ins_buf;
    logic [31:0] kill_addr;
    logic        pc_ld;
    logic        buf_ld;
    logic        kill_ld;

    if_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst      (rst),
        .ld       (pc_ld),
        .redir    (PCSrcD),
        .target   (PCBranchD),
        .pc       (PCF),
        .pc_plus4 (PCPlus4F),
        .err      (FetchErrF)
    );

    // Handshake next-state, PC load control and output muxing
    always_comb begin
        nstate    = state;
        pc_ld     = 1'b0;
        buf_ld    = 1'b0;
        kill_ld   = 1'b0;
        imem_req  = 1'b0;
        imem_addr = PCF;
        Ins       = NOP_INSTR;
        InsValidF = 1'b0;
        if (rst) begin
            unique case (state)
                S_REQ: begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        Ins       = imem_rdata;
                        InsValidF = 1'b1;
                        if (StallF) begin
                            buf_ld = 1'b1;
                            nstate = S_HAVE;
                        end else begin
                            pc_ld = 1'b1;
                        end
                    end else if (PCSrcD) begin
                        pc_ld   = 1'b1;
                        kill_ld = 1'b1;
                        nstate  = S_KILL;
                    end
                end
                S_KILL: begin
                    imem_req  = 1'b1;
                    imem_addr = kill_addr;
                    pc_ld     = PCSrcD;
                    if (imem_ack)
                        nstate = S_REQ;
                end
                S_HAVE: begin
                    Ins       = ins_buf;
                    InsValidF = 1'b1;
                    if (!StallF) begin
                        pc_ld  = 1'b1;
                        nstate = S_REQ;
                    end
                end
                default: nstate = S_REQ;
            endcase
        end
    end

    // Fetch state register
    always_ff @(posedge clk) begin
        if (!rst)
            state <= S_REQ;
        else
            state <= nstate;
    end

    // Buffer for a word acked while the pipeline is stalled
    always_ff @(posedge clk) begin
        if (!rst)
            ins_buf <= NOP_INSTR;
        else if (buf_ld)
            ins_buf <= imem_rdata;
    end

    // Address of the beat being drained after a redirect
    always_ff @(posedge clk) begin
        if (!rst)
            kill_addr <= 32'h0;
        else if (kill_ld)
            kill_addr <= PCF;
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: vector table, directed sequences,
// and randomized traffic against a transaction-level reference model.
module tb_if_stage;

    localparam logic [31:0] RPC = 32'h0040_0000;

`ifdef IF_MISALIGN_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        StallF;
    logic        PCSrcD;
    logic [31:0] PCBranchD;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] Ins;
    logic        InsValidF;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        FetchErrF;

    int waits = 0;
    int cnt = 0;
    bit scr = 1'b0;
    int errs = 0;
    int checks = 0;

    if_stage #(.RESET_PC(RPC)) dut (
        .clk        (clk),
        .rst        (rst),
        .StallF     (StallF),
        .PCSrcD     (PCSrcD),
        .PCBranchD  (PCBranchD),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .Ins        (Ins),
        .InsValidF  (InsValidF),
        .PCF        (PCF),
        .PCPlus4F   (PCPlus4F),
        .FetchErrF  (FetchErrF)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memw(input logic [31:0] a);
        if (a == 32'h0000_0300)
            return 32'h8C01_0004;
        return scr ? (a ^ 32'h5A5A_0F0F) : a;
    endfunction

    // Memory with a programmable wait count; abandons the beat when req drops
    assign imem_ack   = imem_req && (cnt >= waits);
    assign imem_rdata = memw(imem_addr);

    always @(posedge clk) begin
        if (!imem_req || imem_ack)
            cnt <= 0;
        else
            cnt <= cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input bit st, input bit sr, input logic [31:0] tg,
                        input bit ereq, input logic [31:0] eaddr,
                        input bit eval, input logic [31:0] eins,
                        input logic [31:0] epcf, input bit eerr,
                        input string tag);
        StallF    = st;
        PCSrcD    = sr;
        PCBranchD = tg;
        #4;
        chk({tag, " req"}, 32'(imem_req), 32'(ereq));
        if (ereq)
            chk({tag, " addr"}, imem_addr, eaddr);
        chk({tag, " valid"}, 32'(InsValidF), 32'(eval));
        chk({tag, " ins"}, Ins, eins);
        chk({tag, " pcf"}, PCF, epcf);
        chk({tag, " pc+4"}, PCPlus4F, epcf + 32'd4);
        chk({tag, " err"}, 32'(FetchErrF), 32'(eerr));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        StallF    = 1'b0;
        PCSrcD    = 1'b0;
        PCBranchD = 32'h0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #4;
        chk("rst req", 32'(imem_req), 32'h0);
        chk("rst valid", 32'(InsValidF), 32'h0);
        chk("rst ins", Ins, 32'h0);
        chk("rst pcf", PCF, RPC);
        chk("rst pc+4", PCPlus4F, RPC + 32'd4);
        chk("rst err", 32'(FetchErrF), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    typedef struct {
        bit          st;
        bit          sr;
        logic [31:0] tg;
        bit          req;
        logic [31:0] addr;
        bit          val;
        logic [31:0] ins;
        logic [31:0] pcf;
    } vec_t;

    vec_t tbl[14];

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_word;
    logic [31:0] m_dead_addr;
    bit          m_have;
    bit          m_dead;
    bit          m_err;

    function automatic logic [31:0] fix(input logic [31:0] t);
        return CHK ? {t[31:2], 2'b00} : t;
    endfunction

    function automatic bit mis(input logic [31:0] t);
        return CHK && (t[1:0] != 2'b00);
    endfunction

    task automatic redirect_model(input logic [31:0] t);
        m_pc  = fix(t);
        m_err = m_err | mis(t);
    endtask

    initial begin
        logic [31:0] p;
        logic [31:0] t;
        bit          r;
        bit          st;
        bit          sr;
        bit          ereq;
        bit          eval;
        bit          mack;
        logic [31:0] eaddr;
        logic [31:0] eins;

        tbl[0]  = '{0, 0, 32'h0, 1, 32'h0040_0000, 1, 32'h0040_0000, 32'h0040_0000};
        tbl[1]  = '{0, 0, 32'h0, 1, 32'h0040_0004, 1, 32'h0040_0004, 32'h0040_0004};
        tbl[2]  = '{0, 0, 32'h0, 1, 32'h0040_0008, 1, 32'h0040_0008, 32'h0040_0008};
        tbl[3]  = '{0, 1, 32'h300, 1, 32'h0040_000C, 1, 32'h0040_000C, 32'h0040_000C};
        tbl[4]  = '{1, 0, 32'h0, 1, 32'h300, 1, 32'h8C01_0004, 32'h300};
        tbl[5]  = '{1, 0, 32'h0, 0, 32'h300, 1, 32'h8C01_0004, 32'h300};
        tbl[6]  = '{1, 1, 32'h500, 0, 32'h300, 1, 32'h8C01_0004, 32'h300};
        tbl[7]  = '{1, 0, 32'h0, 0, 32'h300, 1, 32'h8C01_0004, 32'h300};
        tbl[8]  = '{0, 0, 32'h0, 0, 32'h300, 1, 32'h8C01_0004, 32'h300};
        tbl[9]  = '{0, 0, 32'h0, 1, 32'h304, 1, 32'h304, 32'h304};
        tbl[10] = '{0, 1, 32'hFFFF_FFFC, 1, 32'h308, 1, 32'h308, 32'h308};
        tbl[11] = '{0, 0, 32'h0, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
        tbl[12] = '{0, 0, 32'h0, 1, 32'h0, 1, 32'h0, 32'h0};
        tbl[13] = '{0, 0, 32'h0, 1, 32'h4, 1, 32'h4, 32'h4};

        // Zero-wait stream, stall hold, wrap
        waits = 0;
        #1;
        do_reset();
        for (int i = 0; i < 14; i++)
            step(tbl[i].st, tbl[i].sr, tbl[i].tg, tbl[i].req, tbl[i].addr,
                 tbl[i].val, tbl[i].ins, tbl[i].pcf, 1'b0,
                 $sformatf("vec%0d", i));

        // Three-wait memory: valid 0,0,0,1 per fetch
        waits = 3;
        do_reset();
        for (int f = 0; f < 2; f++) begin
            p = RPC + 32'(f * 4);
            for (int k = 0; k < 4; k++)
                step(0, 0, 32'h0, 1, p, k == 3, (k == 3) ? p : 32'h0, p, 1'b0,
                     $sformatf("wait3 f%0d c%0d", f, k));
        end

        // Redirect during an outstanding miss
        waits = 0;
        do_reset();
        step(0, 1, 32'h100, 1, RPC, 1, RPC, RPC, 1'b0, "kill go");
        waits = 3;
        step(0, 1, 32'h200, 1, 32'h100, 0, 32'h0, 32'h100, 1'b0, "kill redir");
        for (int k = 0; k < 3; k++)
            step(0, 0, 32'h0, 1, 32'h100, 0, 32'h0, 32'h200, 1'b0,
                 $sformatf("kill drain%0d", k));
        for (int k = 0; k < 4; k++)
            step(0, 0, 32'h0, 1, 32'h200, k == 3, (k == 3) ? 32'h200 : 32'h0,
                 32'h200, 1'b0, $sformatf("kill new%0d", k));

        // Misaligned redirect
        waits = 0;
        do_reset();
        step(0, 1, 32'h203, 1, RPC, 1, RPC, RPC, 1'b0, "mis go");
        p = CHK ? 32'h200 : 32'h203;
        for (int k = 0; k < 3; k++)
            step(0, 0, 32'h0, 1, p + 32'(k * 4), 1, p + 32'(k * 4),
                 p + 32'(k * 4), CHK, $sformatf("mis%0d", k));
        do_reset();

        // Randomized traffic against the reference model
        scr = 1'b1;
        for (int b = 0; b < 8; b++) begin
            waits = $urandom_range(0, 3);
            do_reset();
            m_pc = RPC;
            m_have = 0;
            m_dead = 0;
            m_err = 0;
            m_word = 32'h0;
            m_dead_addr = 32'h0;
            for (int c = 0; c < 150; c++) begin
                r  = ($urandom_range(0, 99) >= 3);
                st = ($urandom_range(0, 99) < 30);
                sr = ($urandom_range(0, 99) < 15);
                t  = $urandom;
                case ($urandom_range(0, 3))
                    0: t[1:0] = 2'b00;
                    1: t = t;
                    2: t = 32'hFFFF_FFFC;
                    default: t = t & 32'h0000_0FFC;
                endcase
                rst       = r;
                StallF    = st;
                PCSrcD    = sr;
                PCBranchD = t;
                #4;
                eaddr = m_pc;
                if (!r) begin
                    ereq = 0;
                    eval = 0;
                    eins = 32'h0;
                end else if (m_dead) begin
                    ereq  = 1;
                    eaddr = m_dead_addr;
                    eval  = 0;
                    eins  = 32'h0;
                end else if (m_have) begin
                    ereq = 0;
                    eval = 1;
                    eins = m_word;
                end else begin
                    ereq = 1;
                    eval = (cnt >= waits);
                    eins = eval ? memw(m_pc) : 32'h0;
                end
                mack = ereq && (cnt >= waits);
                chk("rnd req", 32'(imem_req), 32'(ereq));
                if (ereq)
                    chk("rnd addr", imem_addr, eaddr);
                chk("rnd valid", 32'(InsValidF), 32'(eval));
                chk("rnd ins", Ins, eins);
                chk("rnd pcf", PCF, m_pc);
                chk("rnd pc+4", PCPlus4F, m_pc + 32'd4);
                chk("rnd err", 32'(FetchErrF), 32'(m_err));
                if (!r) begin
                    m_pc = RPC;
                    m_have = 0;
                    m_dead = 0;
                    m_err = 0;
                end else if (m_dead) begin
                    if (sr)
                        redirect_model(t);
                    if (mack)
                        m_dead = 0;
                end else if (m_have) begin
                    if (!st) begin
                        m_have = 0;
                        if (sr)
                            redirect_model(t);
                        else
                            m_pc = m_pc + 32'd4;
                    end
                end else if (mack) begin
                    if (st) begin
                        m_have = 1;
                        m_word = memw(m_pc);
                    end else if (sr) begin
                        redirect_model(t);
                    end else begin
                        m_pc = m_pc + 32'd4;
                    end
                end else if (sr) begin
                    m_dead = 1;
                    m_dead_addr = m_pc;
                    redirect_model(t);
                end
                @(posedge clk);
                #1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
